// File: rtl/bus_master_if_pkg.sv
// Shared encodings for the bus master interface: active-low strobe levels,
// bus direction values and the requester FSM state type.
package bus_master_if_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    BMIF_IDLE   = 2'd0,
    BMIF_REQ    = 2'd1,
    BMIF_ACCESS = 2'd2,
    BMIF_WAIT   = 2'd3
  } bmif_state_t;

endpackage

// File: rtl/bus_master_if.sv
// Requester end of the 4-master arbitrated bus: request, grant, one address
// strobe, wait for slave ready. Optional slave timeout under `BUS_TIMEOUT_EN.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  bmif_state_t       state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_as_q, bus_as_d;
  logic              bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              timeout;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter is cleared on the REQ->ACCESS edge and advances every cycle the
  // slave has not answered; reaching the limit aborts the transaction.
  assign timeout = (state_q == BMIF_ACCESS || state_q == BMIF_WAIT) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == BMIF_REQ && bus_grnt_ == ENABLE_) begin
      cnt_d = '0;
    end else if (state_q == BMIF_ACCESS || state_q == BMIF_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cpu_err = err_q;
`else
  assign timeout = 1'b0;
  assign cpu_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bus_req_d   = bus_req_q;
    bus_as_d    = bus_as_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_data_d   = rd_data_q;
    ack_d       = 1'b0;
`ifdef BUS_TIMEOUT_EN
    err_d       = 1'b0;
`endif

    case (state_q)
      BMIF_IDLE: begin
        if (cpu_req) begin
          rw_d      = cpu_rw;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wr_data;
          bus_req_d = ENABLE_;
          state_d   = BMIF_REQ;
        end
      end

      BMIF_REQ: begin
        bus_req_d = ENABLE_;
        if (bus_grnt_ == ENABLE_) begin
          bus_as_d    = ENABLE_;
          bus_rw_d    = rw_q;
          bus_addr_d  = addr_q;
          bus_wdata_d = wdata_q;
          state_d     = BMIF_ACCESS;
        end
      end

      BMIF_ACCESS, BMIF_WAIT: begin
        // Strobe is a single cycle regardless of how long the slave takes.
        bus_as_d = DISABLE_;
        if (bus_rdy_ == ENABLE_ || timeout) begin
          // Ready beats a simultaneous timeout; bus outputs go OR-mux safe.
          rd_data_d   = (bus_rdy_ == ENABLE_ && rw_q == READ) ? bus_rd_data : '0;
          ack_d       = 1'b1;
`ifdef BUS_TIMEOUT_EN
          err_d       = (bus_rdy_ != ENABLE_);
`endif
          bus_req_d   = DISABLE_;
          bus_rw_d    = READ;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          state_d     = BMIF_IDLE;
        end else begin
          state_d = BMIF_WAIT;
        end
      end

      default: begin
        state_d = BMIF_IDLE;
      end
    endcase

    busy_d = (state_d != BMIF_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BMIF_IDLE;
      rw_q        <= READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_req_q   <= DISABLE_;
      bus_as_q    <= DISABLE_;
      bus_rw_q    <= READ;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_data_q   <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_req_q   <= bus_req_d;
      bus_as_q    <= bus_as_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_data_q   <= rd_data_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_rd_data = rd_data_q;
  assign cpu_busy    = busy_q;
  assign cpu_ack     = ack_q;
  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wdata_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: the bench plays core, registered arbiter
// and slave by hand; outputs are sampled 1 time unit after each rising edge.
module tb_bus_master_if;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  localparam logic EN_  = 1'b0;
  localparam logic DIS_ = 1'b1;
  localparam logic RD   = 1'b1;
  localparam logic WR   = 1'b0;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_busy;
  logic              cpu_ack;
  logic              cpu_err;
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  int n_tests = 0;
  int n_fail  = 0;

  bus_master_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_req     = 1'b1;
    cpu_rw      = rw;
    cpu_addr    = a;
    cpu_wr_data = d;
  endtask

  task automatic bus_idle();
    bus_grnt_ = DIS_;
    bus_rdy_  = DIS_;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_rw = RD; cpu_addr = '0; cpu_wr_data = '0;
    bus_grnt_ = DIS_; bus_rdy_ = DIS_; bus_rd_data = '0;
    tick(); tick();
    check("rst_req_", bus_req_, DIS_);
    check("rst_as_", bus_as_, DIS_);
    check("rst_rw", bus_rw, RD);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wr_data, 0);
    check("rst_rdata", cpu_rd_data, 0);
    check("rst_ack", cpu_ack, 0);
    check("rst_err", cpu_err, 0);
    check("rst_busy", cpu_busy, 0);
    rst = 1'b0;

    // 1: best-case read, ack on the 4th edge after cpu_req
    start(RD, 30'h55, 32'h0);
    tick();
    cpu_req = 1'b0;
    check("t1_req_low", bus_req_, EN_);
    check("t1_busy", cpu_busy, 1);
    tick();
    check("t1_as_wait_grant", bus_as_, DIS_);
    bus_grnt_ = EN_;
    tick();
    check("t1_as_low", bus_as_, EN_);
    check("t1_addr", bus_addr, 30'h55);
    check("t1_rw", bus_rw, RD);
    bus_rdy_ = EN_; bus_rd_data = 32'hDEADBEEF;
    tick();
    check("t1_ack", cpu_ack, 1);
    check("t1_rdata", cpu_rd_data, 32'hDEADBEEF);
    check("t1_err", cpu_err, 0);
    check("t1_req_high", bus_req_, DIS_);
    check("t1_as_high", bus_as_, DIS_);
    check("t1_addr_idle", bus_addr, 0);
    check("t1_busy_idle", cpu_busy, 0);
    bus_idle();
    tick();
    check("t1_ack_pulse", cpu_ack, 0);

    // 2: write with three WAIT cycles before ready
    start(WR, 30'h100, 32'h12345678);
    tick();
    cpu_req = 1'b0;
    tick();
    bus_grnt_ = EN_;
    tick();
    check("t2_as_low", bus_as_, EN_);
    check("t2_rw", bus_rw, WR);
    check("t2_addr", bus_addr, 30'h100);
    check("t2_wdata", bus_wr_data, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_wait_as_", bus_as_, DIS_);
      check("t2_wait_addr", bus_addr, 30'h100);
      check("t2_wait_wdata", bus_wr_data, 32'h12345678);
      check("t2_wait_req_", bus_req_, EN_);
      check("t2_wait_ack", cpu_ack, 0);
    end
    bus_rdy_ = EN_; bus_rd_data = 32'hFFFF0000;
    tick();
    check("t2_ack", cpu_ack, 1);
    check("t2_err", cpu_err, 0);
    check("t2_rdata_zero", cpu_rd_data, 0);
    check("t2_wdata_idle", bus_wr_data, 0);
    check("t2_rw_idle", bus_rw, RD);
    bus_idle();
    tick();

    // 3: grant withheld 10 cycles while the slave toggles ready
    start(RD, 30'h2A, 32'h0);
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_rdy_ = (i % 2 == 0) ? EN_ : DIS_;
      tick();
      check("t3_req_held", bus_req_, EN_);
      check("t3_as_high", bus_as_, DIS_);
      check("t3_no_ack", cpu_ack, 0);
    end
    bus_rdy_ = DIS_;
    bus_grnt_ = EN_;
    tick();
    check("t3_as_low", bus_as_, EN_);
    bus_rdy_ = EN_; bus_rd_data = 32'hA5A5A5A5;
    tick();
    check("t3_ack", cpu_ack, 1);
    check("t3_rdata", cpu_rd_data, 32'hA5A5A5A5);
    bus_idle();
    tick();

    // 4: back-to-back reads with cpu_req held high
    start(RD, 30'h200, 32'h0);
    tick();
    tick();
    bus_grnt_ = EN_;
    tick();
    bus_rdy_ = EN_; bus_rd_data = 32'h11111111;
    tick();
    check("t4_ack1", cpu_ack, 1);
    check("t4_rdata1", cpu_rd_data, 32'h11111111);
    check("t4_req_gap", bus_req_, DIS_);
    cpu_addr = 30'h204;
    bus_idle();
    tick();
    check("t4_req_again", bus_req_, EN_);
    check("t4_busy2", cpu_busy, 1);
    check("t4_ack_pulse", cpu_ack, 0);
    cpu_req = 1'b0;
    tick();
    bus_grnt_ = EN_;
    tick();
    check("t4_addr2", bus_addr, 30'h204);
    bus_rdy_ = EN_; bus_rd_data = 32'h22222222;
    tick();
    check("t4_ack2", cpu_ack, 1);
    check("t4_rdata2", cpu_rd_data, 32'h22222222);
    bus_idle();
    tick();

    // 5: slave never answers
    start(RD, 30'h300, 32'h0);
    tick();
    cpu_req = 1'b0;
    tick();
    bus_grnt_ = EN_;
    tick();
    check("t5_as_low", bus_as_, EN_);
    bus_rd_data = 32'h5555AAAA;
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      check("t5_no_ack_yet", cpu_ack, 0);
    end
    tick();
    check("t5_tmo_ack", cpu_ack, 1);
    check("t5_tmo_err", cpu_err, 1);
    check("t5_tmo_rdata", cpu_rd_data, 0);
    check("t5_tmo_req_", bus_req_, DIS_);
    check("t5_tmo_idle", cpu_busy, 0);
    bus_idle();
    tick();
    check("t5_err_pulse", cpu_err, 0);
    // ready arriving on the limit cycle completes normally
    start(RD, 30'h304, 32'h0);
    tick();
    cpu_req = 1'b0;
    tick();
    bus_grnt_ = EN_;
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    bus_rdy_ = EN_; bus_rd_data = 32'hCAFEF00D;
    tick();
    check("t5_edge_ack", cpu_ack, 1);
    check("t5_edge_err", cpu_err, 0);
    check("t5_edge_rdata", cpu_rd_data, 32'hCAFEF00D);
`else
    for (int i = 0; i < 100; i++) tick();
    check("t5_still_busy", cpu_busy, 1);
    check("t5_no_ack", cpu_ack, 0);
    check("t5_req_held", bus_req_, EN_);
    bus_rdy_ = EN_;
    tick();
    check("t5_late_ack", cpu_ack, 1);
    check("t5_late_rdata", cpu_rd_data, 32'h5555AAAA);
    check("t5_err_tied", cpu_err, 0);
`endif
    bus_idle();
    tick();

    // 6: reset while waiting on the slave, then a clean transaction
    start(WR, 30'h400, 32'h87654321);
    tick();
    cpu_req = 1'b0;
    tick();
    bus_grnt_ = EN_;
    tick();
    tick();
    check("t6_in_wait", bus_as_, DIS_);
    check("t6_wait_addr", bus_addr, 30'h400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_req_", bus_req_, DIS_);
    check("t6_as_", bus_as_, DIS_);
    check("t6_rw", bus_rw, RD);
    check("t6_addr", bus_addr, 0);
    check("t6_wdata", bus_wr_data, 0);
    check("t6_rdata", cpu_rd_data, 0);
    check("t6_ack", cpu_ack, 0);
    check("t6_busy", cpu_busy, 0);
    bus_idle();
    tick();
    check("t6_no_late_ack", cpu_ack, 0);
    start(RD, 30'h500, 32'h0);
    tick();
    cpu_req = 1'b0;
    tick();
    bus_grnt_ = EN_;
    tick();
    check("t6_new_addr", bus_addr, 30'h500);
    bus_rdy_ = EN_; bus_rd_data = 32'h0BADF00D;
    tick();
    check("t6_new_ack", cpu_ack, 1);
    check("t6_new_rdata", cpu_rd_data, 32'h0BADF00D);
    bus_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
